// File: rtl/keypad_row_decoder.sv
// keypad_row_decoder: scans a 4x4 active-low keypad matrix, debounces press and release,
// and reports the key code with a one-cycle strobe. Define KEYPAD_REPEAT_EN for auto-repeat while held.
module keypad_row_decoder #(
    parameter int SCAN_DIV      = 16,
    parameter int DB_CYCLES     = 1000,
    parameter int REPEAT_CYCLES = 50000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);

    // Out-of-range configurations elaborate this empty marker so they stand out in the hierarchy.
    if (SCAN_DIV < 3 || DB_CYCLES < 1 || REPEAT_CYCLES < 1 || CNT_W < 2 || CNT_W > 30 ||
        SCAN_DIV > (1 << CNT_W) || DB_CYCLES > (1 << CNT_W) || REPEAT_CYCLES > (1 << CNT_W))
    begin : g_badConfig
    end

    state_t           state_q;
    logic [3:0]       rowsMeta_q;
    logic [3:0]       rowsSync_q;
    logic [3:0]       cols_q;
    logic [1:0]       colIdx_q;
    logic [1:0]       rowIdx_q;
    logic [CNT_W-1:0] divCnt_q;
    logic [CNT_W-1:0] dbCnt_q;
    logic [3:0]       key_q;
    logic             keyValid_q;
    logic             keyHeld_q;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] repCnt_q;
`endif

    logic [1:0]       lowRow_d;
    logic             anyLow_d;
    logic             rowLow_d;
    logic [3:0]       colsNext_d;

    // Lowest-indexed low row wins when several keys share the driven column.
    always_comb begin
        lowRow_d = 2'd0;
        if (!rowsSync_q[0]) begin
            lowRow_d = 2'd0;
        end else if (!rowsSync_q[1]) begin
            lowRow_d = 2'd1;
        end else if (!rowsSync_q[2]) begin
            lowRow_d = 2'd2;
        end else if (!rowsSync_q[3]) begin
            lowRow_d = 2'd3;
        end
    end

    assign anyLow_d   = ~&rowsSync_q;
    assign rowLow_d   = ~rowsSync_q[rowIdx_q];
    assign colsNext_d = {cols_q[2:0], cols_q[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SCAN;
            rowsMeta_q <= 4'b1111;
            rowsSync_q <= 4'b1111;
            cols_q     <= 4'b1110;
            colIdx_q   <= 2'd0;
            rowIdx_q   <= 2'd0;
            divCnt_q   <= '0;
            dbCnt_q    <= '0;
            key_q      <= 4'd0;
            keyValid_q <= 1'b0;
            keyHeld_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            repCnt_q   <= '0;
`endif
        end else begin
            rowsMeta_q <= rows;
            rowsSync_q <= rowsMeta_q;
            keyValid_q <= 1'b0;

            case (state_q)
                SCAN: begin
                    if (divCnt_q == DIV_LAST) begin
                        divCnt_q <= '0;
                        if (anyLow_d) begin
                            rowIdx_q <= lowRow_d;
                            dbCnt_q  <= '0;
                            state_q  <= DEBOUNCE;
                        end else begin
                            cols_q   <= colsNext_d;
                            colIdx_q <= colIdx_q + 2'd1;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + CNT_W'(1);
                    end
                end

                DEBOUNCE: begin
                    if (!rowLow_d) begin
                        state_q  <= SCAN;
                        divCnt_q <= '0;
                        cols_q   <= colsNext_d;
                        colIdx_q <= colIdx_q + 2'd1;
                    end else if (dbCnt_q == DB_LAST) begin
                        key_q      <= {rowIdx_q, colIdx_q};
                        keyValid_q <= 1'b1;
                        keyHeld_q  <= 1'b1;
                        state_q    <= HELD;
`ifdef KEYPAD_REPEAT_EN
                        repCnt_q   <= '0;
`endif
                    end else begin
                        dbCnt_q <= dbCnt_q + CNT_W'(1);
                    end
                end

                // Only the latched row matters here; other rows cannot start a second key.
                HELD: begin
                    if (!rowLow_d) begin
                        state_q <= RELEASE;
                        dbCnt_q <= '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (repCnt_q == REP_LAST) begin
                        keyValid_q <= 1'b1;
                        repCnt_q   <= '0;
                    end else begin
                        repCnt_q <= repCnt_q + CNT_W'(1);
                    end
`endif
                end

                RELEASE: begin
                    if (rowLow_d) begin
                        state_q  <= HELD;
`ifdef KEYPAD_REPEAT_EN
                        repCnt_q <= '0;
`endif
                    end else if (dbCnt_q == DB_LAST) begin
                        keyHeld_q <= 1'b0;
                        state_q   <= SCAN;
                        divCnt_q  <= '0;
                        cols_q    <= colsNext_d;
                        colIdx_q  <= colIdx_q + 2'd1;
                    end else begin
                        dbCnt_q <= dbCnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign cols      = cols_q;
    assign key       = key_q;
    assign key_valid = keyValid_q;
    assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_row_decoder.sv
// Bench for keypad_row_decoder: a keypad matrix model drives rows from cols; a scoreboard
// queue holds expected key codes and a negedge monitor checks every key_valid strobe.
`timescale 1ns/1ps
module tb_keypad_row_decoder;

    localparam int SCAN_DIV      = 4;
    localparam int DB_CYCLES     = 8;
    localparam int REPEAT_CYCLES = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed = 16'h0000;
    logic [3:0]  glitchRows = 4'hF;
    logic [3:0]  keypadRows;

    int          checks = 0;
    int          failures = 0;
    logic [3:0]  sbQ[$];
    logic [3:0]  monExp;

    keypad_row_decoder #(
        .SCAN_DIV      (SCAN_DIV),
        .DB_CYCLES     (DB_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .CNT_W         (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // A pressed switch pulls its row low only while its column is driven low.
    always_comb begin
        keypadRows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*r+c] && !cols[c]) keypadRows[r] = 1'b0;
            end
        end
    end

    assign rows = keypadRows & glitchRows;

    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (sbQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_key_valid actual key=%0h required no strobe", key);
            end else begin
                monExp = sbQ.pop_front();
                if (key !== monExp) begin
                    failures++;
                    $display("[TB] FAIL strobe_key actual=%0h required=%0h", key, monExp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys);
        pressed = keys;
    endtask

    task automatic waitScoreboard(input int budget, input string name);
        int n = 0;
        while (sbQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s actual pending=%0d required pending=0", name, sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic waitHeldLow(input int budget, input string name);
        int n = 0;
        while (key_held && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, key_held, 1'b0);
    endtask

    task automatic waitColEntry(input logic [3:0] target, input int budget);
        logic [3:0] prev;
        int n = 0;
        bit found = 0;
        while (!found && n < budget) begin
            prev = cols;
            @(negedge clk);
            n++;
            if (cols == target && prev != target) found = 1;
        end
        checkOutput("col_entry", cols, target);
    endtask

    initial begin
        logic [3:0] rotTab[4];
        int lat;
        rotTab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        $display("[TB] reset and idle scan");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_cols", cols, 4'b1110);
        checkOutput("reset_key", key, 4'h0);
        checkOutput("reset_valid", key_valid, 1'b0);
        checkOutput("reset_held", key_held, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checkOutput("idle_scan_cols", cols, rotTab[(k/4)%4]);
            @(negedge clk);
        end

        $display("[TB] press row2/col2 then release");
        sbQ.push_back(4'hA);
        applyStimulus(16'h1 << 10);
        waitScoreboard(60, "press_A_strobe");
        checkOutput("press_A_key", key, 4'hA);
        checkOutput("press_A_held", key_held, 1'b1);
        applyStimulus(16'h0000);
        repeat (9) @(negedge clk);
        checkOutput("release_A_still_held", key_held, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("release_A_dropped", key_held, 1'b0);
        checkOutput("release_A_next_col", cols, 4'b0111);
        checkOutput("release_A_key_kept", key, 4'hA);
        repeat (4) @(negedge clk);
        checkOutput("release_A_scan_resumes", cols, 4'b1110);

        $display("[TB] three-cycle glitch on row1");
        waitColEntry(4'b1101, 40);
        glitchRows = 4'b1101;
        repeat (3) @(negedge clk);
        glitchRows = 4'hF;
        @(negedge clk);
        checkOutput("glitch_cols_frozen", cols, 4'b1101);
        repeat (2) @(negedge clk);
        checkOutput("glitch_scan_advance", cols, 4'b1011);

        $display("[TB] bounce while held on row1/col3");
        sbQ.push_back(4'h7);
        applyStimulus(16'h1 << 7);
        waitScoreboard(60, "press_7_strobe");
        applyStimulus(16'h0000);
        repeat (3) @(negedge clk);
        applyStimulus(16'h1 << 7);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("bounce_held", key_held, 1'b1);
        end
        applyStimulus(16'h0000);
        waitHeldLow(20, "bounce_release");

        $display("[TB] two rows low on col1");
        sbQ.push_back(4'h1);
        applyStimulus((16'h1 << 1) | (16'h1 << 13));
        waitScoreboard(60, "multi_row_strobe");
        checkOutput("multi_row_key", key, 4'h1);
        applyStimulus(16'h0000);
        waitHeldLow(20, "multi_row_release");

`ifdef KEYPAD_REPEAT_EN
        $display("[TB] auto-repeat on row1/col1");
        begin
            int pulses = 0;
            int n = 0;
            for (int i = 0; i < 4; i++) sbQ.push_back(4'h5);
            applyStimulus(16'h1 << 5);
            while (!key_valid && n < 60) begin
                @(negedge clk);
                n++;
            end
            checkOutput("repeat_first_strobe", key_valid, 1'b1);
            for (int i = 1; i <= 70; i++) begin
                @(negedge clk);
                if (key_valid) begin
                    pulses++;
                    checkOutput("repeat_spacing", i, 20 * pulses);
                end
            end
            checkOutput("repeat_count", pulses, 3);
            applyStimulus(16'h0000);
            waitHeldLow(20, "repeat_release");
            waitScoreboard(2, "repeat_drain");
        end
`endif

        $display("[TB] reset during debounce and during held");
        applyStimulus(16'h1 << 8);
        waitColEntry(4'b1110, 40);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_db_cols", cols, 4'b1110);
        checkOutput("rst_db_key", key, 4'h0);
        checkOutput("rst_db_valid", key_valid, 1'b0);
        checkOutput("rst_db_held", key_held, 1'b0);
        @(negedge clk);
        sbQ.push_back(4'h8);
        reset = 1'b0;
        lat = 0;
        while (!key_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("repress_latency", lat, 12);
        waitScoreboard(2, "repress_strobe");
        repeat (5) @(negedge clk);
        checkOutput("repress_held", key_held, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("rst_held_held", key_held, 1'b0);
        checkOutput("rst_held_key", key, 4'h0);
        checkOutput("rst_held_cols", cols, 4'b1110);
        applyStimulus(16'h0000);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_scan", cols, 4'b1101);
        repeat (12) @(negedge clk);
        checkOutput("scoreboard_drained", sbQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
